// File: rtl/recip_share_ctrl_if.sv
// Bundle between the reciprocal-share controller, its requesters and the shared reciprocal unit.
// The controller connects through the slave modport; the requesters and the unit drive the master side.
interface recip_share_ctrl_if #(
    parameter int NUM_REQ = 4,
    parameter int DIV_W   = 8,
    parameter int Q_W     = 32
);
    logic [NUM_REQ-1:0]       i_req;
    logic [NUM_REQ*DIV_W-1:0] i_req_divisor;
    logic [NUM_REQ-1:0]       o_ack;
    logic [Q_W-1:0]           o_quotient;
    logic                     o_err;
    logic                     o_busy;
    logic                     o_div_clear;
    logic                     o_div_valid;
    logic [DIV_W-1:0]         o_div_divisor;
    logic                     i_div_valid;
    logic [Q_W-1:0]           i_div_quotient;

    modport slave (
        input  i_req, i_req_divisor, i_div_valid, i_div_quotient,
        output o_ack, o_quotient, o_err, o_busy, o_div_clear, o_div_valid, o_div_divisor
    );

    modport master (
        output i_req, i_req_divisor, i_div_valid, i_div_quotient,
        input  o_ack, o_quotient, o_err, o_busy, o_div_clear, o_div_valid, o_div_divisor
    );
endinterface

// File: rtl/recip_share_ctrl.sv
// Time-shares one reciprocal unit among NUM_REQ requesters with round-robin arbitration,
// local divide-by-zero handling and a BUSY timeout that aborts a hung unit.
module recip_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int DIV_W   = 8,
    parameter int Q_W     = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    recip_share_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   last_grant_reg;
    logic [IDX_W-1:0]   winner_reg;
    logic [NUM_REQ-1:0] mask_reg;
    logic [DIV_W-1:0]   divisor_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [NUM_REQ-1:0] ack_reg;
    logic [Q_W-1:0]     quotient_reg;
    logic               err_reg;
    logic               busy_reg;
    logic               div_clear_reg;
    logic               div_valid_reg;
    logic [DIV_W-1:0]   div_divisor_reg;

    logic [DIV_W-1:0]   req_div [NUM_REQ];
    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [DIV_W-1:0]   pick_div;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // cand_idx[gi] is the requester (gi+1) places after the last grant, wrapped mod NUM_REQ.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            logic [IDX_W:0] sum;
            assign req_div[gi]  = bus.i_req_divisor[gi*DIV_W +: DIV_W];
            assign sum          = {1'b0, last_grant_reg} + (IDX_W+1)'(gi + 1);
            assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ?
                                  IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : sum[IDX_W-1:0];
        end
    endgenerate

    assign eligible = bus.i_req & ~mask_reg;

    // Scan farthest-first so the nearest eligible slot after the last grant wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[cand_idx[i]]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx[i];
            end
        end
    end

    assign pick_div = req_div[pick_idx];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg       <= S_IDLE;
            last_grant_reg  <= IDX_LAST;
            winner_reg      <= '0;
            mask_reg        <= '0;
            divisor_reg     <= '0;
            cnt_reg         <= '0;
            ack_reg         <= '0;
            quotient_reg    <= '0;
            err_reg         <= 1'b0;
            busy_reg        <= 1'b0;
            div_clear_reg   <= 1'b0;
            div_valid_reg   <= 1'b0;
            div_divisor_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    mask_reg <= '0;
                    cnt_reg  <= '0;
                    if (pick_found) begin
                        winner_reg  <= pick_idx;
                        divisor_reg <= pick_div;
                        busy_reg    <= 1'b1;
                        if (pick_div == '0) begin
                            // Divide-by-zero is answered locally; the unit never sees it.
                            state_reg    <= S_DONE;
                            ack_reg      <= onehot(pick_idx);
                            quotient_reg <= '1;
                            err_reg      <= 1'b0;
                        end else begin
                            state_reg     <= S_CLEAR;
                            div_clear_reg <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    div_clear_reg   <= 1'b0;
                    div_valid_reg   <= 1'b1;
                    div_divisor_reg <= divisor_reg;
                    state_reg       <= S_BUSY;
                end
                S_BUSY: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    // A result arriving on the final timeout cycle still counts as valid.
                    if (bus.i_div_valid || (cnt_reg == CNT_LAST)) begin
                        state_reg       <= S_DONE;
                        div_valid_reg   <= 1'b0;
                        div_divisor_reg <= '0;
                        ack_reg         <= onehot(winner_reg);
                        quotient_reg    <= bus.i_div_valid ? bus.i_div_quotient : '0;
                        err_reg         <= ~bus.i_div_valid;
                    end
                end
                S_DONE: begin
                    ack_reg        <= '0;
                    quotient_reg   <= '0;
                    err_reg        <= 1'b0;
                    busy_reg       <= 1'b0;
                    last_grant_reg <= winner_reg;
                    mask_reg       <= onehot(winner_reg);
                    state_reg      <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.o_ack         = ack_reg;
    assign bus.o_quotient    = quotient_reg;
    assign bus.o_err         = err_reg;
    assign bus.o_busy        = busy_reg;
    assign bus.o_div_clear   = div_clear_reg;
    assign bus.o_div_valid   = div_valid_reg;
    assign bus.o_div_divisor = div_divisor_reg;
endmodule

// File: tb/tb_recip_share_ctrl.sv
// Self-checking bench for recip_share_ctrl: requester and reciprocal-unit models drive the DUT,
// a transaction-timeline model predicts every output each cycle, plus directed literal checks.
module tb_recip_share_ctrl;
    localparam int NR     = 4;
    localparam int DW     = 8;
    localparam int QW     = 32;
    localparam int TO     = 64;
    localparam int PLAN_N = 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    recip_share_ctrl_if #(.NUM_REQ(NR), .DIV_W(DW), .Q_W(QW)) bus ();

    recip_share_ctrl #(.NUM_REQ(NR), .DIV_W(DW), .Q_W(QW), .TIMEOUT(TO)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [NR-1:0]    req;
    logic [NR*DW-1:0] req_div;
    bit               rr_mode   = 1'b0;
    bit               rand_mode = 1'b0;

    // Per-operation unit behaviour: respond on the k-th launch cycle (k > TO means never).
    int unsigned plan_k [PLAN_N];
    logic [31:0] plan_q [PLAN_N];

    // Reference model: one operation in flight, described by its grant cycle and length.
    bit          m_act;
    int          m_g, m_w, m_len, m_last;
    int          m_op = 0;
    logic [7:0]  m_div;
    bit          m_zero, m_err;
    logic [31:0] m_res;
    logic [NR-1:0] m_mask;

    // Reciprocal unit model.
    bit          u_act;
    int          u_cnt, u_k;
    int          u_op = 0;
    logic [31:0] u_q;

    // Observations used by the directed checks.
    int          obs_ack_cyc;
    logic [NR-1:0] obs_ack;
    logic [31:0] obs_q;
    logic        obs_err;
    int          obs_clr, obs_vld;
    bit          obs_new_ack;
    int          ack_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int op_end();
        return m_zero ? 1 : m_len + 2;
    endfunction

    task automatic model_reset();
        m_act  = 1'b0;
        m_last = NR - 1;
        m_mask = '0;
        u_act  = 1'b0;
        u_cnt  = 0;
        req    = '0;
        bus.i_req          = '0;
        bus.i_div_valid    = 1'b0;
        bus.i_div_quotient = '0;
    endtask

    task automatic clear_obs();
        obs_clr = 0;
        obs_vld = 0;
        obs_new_ack = 1'b0;
        ack_log.delete();
    endtask

    task automatic step(input logic [NR-1:0] raise = '0, input logic [NR*DW-1:0] raise_div = '0);
        logic [NR-1:0] eack, elig, acked;
        logic eclr, evld, eerr, ebusy, u_dv, found;
        logic [31:0] u_dq;
        int rel, k;
        @(negedge clk);
        cyc++;
        // expected outputs for this cycle from the in-flight operation timeline
        eack = '0; eclr = 1'b0; evld = 1'b0; eerr = 1'b0; ebusy = 1'b0;
        if (m_act) begin
            rel   = cyc - m_g;
            ebusy = 1'b1;
            if (rel == op_end()) begin
                eack[m_w] = 1'b1;
                eerr      = m_err;
            end
            eclr = !m_zero && (rel == 1);
            evld = !m_zero && (rel >= 2) && (rel <= m_len + 1);
        end
        chk("ctrl_outputs", {bus.o_ack, bus.o_div_clear, bus.o_div_valid, bus.o_err, bus.o_busy},
            {eack, eclr, evld, eerr, ebusy});
        if (eack != '0) chk("quotient", bus.o_quotient, m_res);
        if (evld) chk("div_divisor", bus.o_div_divisor, m_div);

        acked = bus.o_ack;
        if (acked != '0) begin
            obs_ack_cyc = cyc;
            obs_ack     = acked;
            obs_q       = bus.o_quotient;
            obs_err     = bus.o_err;
            obs_new_ack = 1'b1;
            for (int i = 0; i < NR; i++) if (acked[i]) ack_log.push_back(i);
            $display("ack req=%b q=%h err=%b cycle=%0d", acked, bus.o_quotient, bus.o_err, cyc);
        end
        if (bus.o_div_clear) obs_clr++;
        if (bus.o_div_valid) obs_vld++;

        // reciprocal unit: counts launch cycles, noise on i_div_valid whenever it must be ignored
        u_dv = 1'b0;
        u_dq = $urandom;
        if (bus.o_div_clear) begin
            u_act = 1'b1;
            u_cnt = 0;
            u_k   = plan_k[u_op % PLAN_N];
            u_q   = plan_q[u_op % PLAN_N];
            u_op++;
            u_dv  = ($urandom_range(0, 3) == 0);
        end else if (bus.o_div_valid) begin
            if (u_act) begin
                u_cnt++;
                if (u_cnt == u_k) begin
                    u_dv  = 1'b1;
                    u_dq  = u_q;
                    u_act = 1'b0;
                end
            end
        end else begin
            u_dv = ($urandom_range(0, 3) == 0);
        end
        bus.i_div_valid    = u_dv;
        bus.i_div_quotient = u_dq;

        // requesters: drop on ack, raise by directed request or mode
        req = req & ~acked;
        for (int i = 0; i < NR; i++) begin
            if (!req[i] && !acked[i]) begin
                if (raise[i]) begin
                    req[i] = 1'b1;
                    req_div[i*DW +: DW] = raise_div[i*DW +: DW];
                end else if (rr_mode || (rand_mode && $urandom_range(0, 7) == 0)) begin
                    req[i] = 1'b1;
                    req_div[i*DW +: DW] = (rand_mode && $urandom_range(0, 4) == 0) ?
                                          8'd0 : 8'($urandom_range(1, 255));
                end
            end
        end
        bus.i_req         = req;
        bus.i_req_divisor = req_div;

        // model consumes the inputs the DUT samples at the coming edge
        if (m_act && (cyc - m_g) == op_end()) begin
            m_act     = 1'b0;
            m_last    = m_w;
            m_mask    = '0;
            m_mask[m_w] = 1'b1;
        end else if (!m_act) begin
            elig   = req & ~m_mask;
            m_mask = '0;
            found  = 1'b0;
            for (int off = 1; off <= NR; off++) begin
                int c;
                c = (m_last + off) % NR;
                if (!found && elig[c]) begin
                    found = 1'b1;
                    m_w   = c;
                end
            end
            if (found) begin
                m_act  = 1'b1;
                m_g    = cyc;
                m_div  = req_div[m_w*DW +: DW];
                m_zero = (m_div == 8'd0);
                if (m_zero) begin
                    m_res = 32'hFFFF_FFFF;
                    m_err = 1'b0;
                    m_len = 0;
                end else begin
                    k = plan_k[m_op % PLAN_N];
                    m_len = (k <= TO) ? k : TO;
                    m_res = (k <= TO) ? plan_q[m_op % PLAN_N] : 32'h0;
                    m_err = (k > TO);
                    m_op++;
                end
            end
        end
    endtask

    task automatic wait_ack(input string name);
        obs_new_ack = 1'b0;
        for (int n = 0; n < 300 && !obs_new_ack; n++) step();
        chk({name, "_ack_seen"}, obs_new_ack, 1'b1);
    endtask

    task automatic set_plan(input int idx, input int unsigned k, input logic [31:0] q);
        plan_k[idx % PLAN_N] = k;
        plan_q[idx % PLAN_N] = q;
    endtask

    task automatic full_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {bus.o_ack, bus.o_div_clear, bus.o_div_valid, bus.o_err, bus.o_busy}, '0);
        chk("reset_data", {bus.o_quotient, bus.o_div_divisor}, '0);
        rst_n = 1'b1;
    endtask

    int t0;
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        req     = '0;
        req_div = '0;
        bus.i_req_divisor = '0;
        for (int i = 0; i < PLAN_N; i++) begin
            int r;
            r = $urandom_range(0, 9);
            plan_k[i] = (r == 0) ? 70 : (r == 1) ? 64 : (r == 2) ? 65 : $urandom_range(1, 8);
            plan_q[i] = $urandom;
        end
        full_reset();
        clear_obs();

        // single requester, L = 5
        set_plan(m_op, 5, 32'h4000_0000);
        step(4'b0100, 32'h0004_0000);
        t0 = cyc;
        wait_ack("single");
        chk("single_latency", obs_ack_cyc - t0, 7);
        chk("single_ack", obs_ack, 4'b0100);
        chk("single_q", obs_q, 32'h4000_0000);
        chk("single_err", obs_err, 1'b0);
        chk("single_clear_cnt", obs_clr, 1);
        chk("single_valid_cnt", obs_vld, 5);
        repeat (3) step();

        // round-robin from reset with all four requesting continuously
        full_reset();
        clear_obs();
        for (int i = 0; i < 8; i++) set_plan(m_op + i, 2, 32'hA000_0000 + i);
        rr_mode = 1'b1;
        step(4'b1111, 32'h0506_0708);
        for (int n = 0; n < 400 && ack_log.size() < 6; n++) step();
        rr_mode = 1'b0;
        chk("rr_ack_count", ack_log.size() >= 6, 1'b1);
        for (int i = 0; i < 6; i++) chk($sformatf("rr_grant_%0d", i), (i < ack_log.size()) ? ack_log[i] : -1, exp_order[i]);
        for (int n = 0; n < 400 && (req != '0 || m_act); n++) step();
        chk("rr_drained", (req != '0) || m_act, 1'b0);
        step();

        // zero divisor
        clear_obs();
        step(4'b0010, 32'h0);
        t0 = cyc;
        wait_ack("zero");
        chk("zero_latency", obs_ack_cyc - t0, 1);
        chk("zero_ack", obs_ack, 4'b0010);
        chk("zero_q", obs_q, 32'hFFFF_FFFF);
        chk("zero_unit_untouched", obs_clr + obs_vld, 0);
        step();

        // timeout, then a normal operation
        clear_obs();
        set_plan(m_op, 1000, 32'h0);
        step(4'b0001, 32'h0000_0009);
        wait_ack("timeout");
        chk("timeout_valid_cnt", obs_vld, 64);
        chk("timeout_q", obs_q, 32'h0);
        chk("timeout_err", obs_err, 1'b1);
        clear_obs();
        set_plan(m_op, 3, 32'hCAFE_F00D);
        step(4'b1000, 32'h0500_0000);
        wait_ack("after_timeout");
        chk("after_timeout_ack", obs_ack, 4'b1000);
        chk("after_timeout_q", obs_q, 32'hCAFE_F00D);
        chk("after_timeout_err", obs_err, 1'b0);
        step();

        // valid result on the final timeout cycle
        clear_obs();
        set_plan(m_op, 64, 32'h1234_5678);
        step(4'b0100, 32'h0003_0000);
        wait_ack("tie");
        chk("tie_q", obs_q, 32'h1234_5678);
        chk("tie_err", obs_err, 1'b0);
        chk("tie_valid_cnt", obs_vld, 64);
        step();

        // reset in the middle of BUSY
        clear_obs();
        set_plan(m_op, 1000, 32'h0);
        step(4'b0010, 32'h0000_0700);
        for (int n = 0; n < 50 && obs_vld < 10; n++) step();
        chk("midreset_in_busy", bus.o_div_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midreset_ctrl", {bus.o_ack, bus.o_div_clear, bus.o_div_valid, bus.o_err, bus.o_busy}, '0);
        chk("midreset_data", {bus.o_quotient, bus.o_div_divisor}, '0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        set_plan(m_op, 2, 32'h0000_1111);
        set_plan(m_op + 1, 2, 32'h0000_2222);
        step(4'b1001, 32'h0600_0003);
        wait_ack("post_reset_first");
        chk("post_reset_first_ack", obs_ack, 4'b0001);
        wait_ack("post_reset_second");
        chk("post_reset_second_ack", obs_ack, 4'b1000);
        step();

        // randomized traffic
        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0;
        for (int n = 0; n < 500 && (req != '0 || m_act); n++) step();
        chk("random_drained", (req != '0) || m_act, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
